// File: rtl/mchan_cmd_unpack.sv
// Assembles 3 (1D) or 5 (2D) MCHAN command words into one transfer descriptor.
// Optional macro MCHAN_CMD_LEN_CHECK_EN rejects word0 with len == 0 or len > 2^(LEN_WIDTH-1).
module mchan_cmd_unpack #(
    parameter int ADDR_WIDTH       = 32,
    parameter int LEN_WIDTH        = 17,
    parameter int TWD_COUNT_WIDTH  = 32,
    parameter int TWD_STRIDE_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_req_i,
    input  logic [31:0]                 cmd_wdata_i,
    output logic                        cmd_gnt_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LEN_WIDTH-1:0]        out_len_o,
    output logic                        out_opc_o,
    output logic                        out_inc_o,
    output logic                        out_twd_o,
    output logic [ADDR_WIDTH-1:0]       out_tcdm_add_o,
    output logic [ADDR_WIDTH-1:0]       out_ext_add_o,
    output logic [TWD_COUNT_WIDTH-1:0]  out_twd_count_o,
    output logic [TWD_STRIDE_WIDTH-1:0] out_twd_stride_o,
    output logic                        busy_o,
    output logic                        err_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_TCDM, ST_EXT, ST_COUNT, ST_STRIDE, ST_PEND
    } state_e;

    state_e                        state_q,  state_d;
    logic [LEN_WIDTH-1:0]          len_q,    len_d;
    logic                          opc_q,    opc_d;
    logic                          inc_q,    inc_d;
    logic                          twd_q,    twd_d;
    logic [ADDR_WIDTH-1:0]         tcdm_q,   tcdm_d;
    logic [ADDR_WIDTH-1:0]         ext_q,    ext_d;
    logic [TWD_COUNT_WIDTH-1:0]    count_q,  count_d;
    logic [TWD_STRIDE_WIDTH-1:0]   stride_q, stride_d;

    logic                          accept;
    logic                          len_bad;
    logic [LEN_WIDTH-1:0]          w0_len;

    assign w0_len = cmd_wdata_i[LEN_WIDTH-1:0];
    assign accept = cmd_req_i && (state_q != ST_PEND);

`ifdef MCHAN_CMD_LEN_CHECK_EN
    localparam logic [LEN_WIDTH:0] LEN_LIMIT = {2'b01, {(LEN_WIDTH-1){1'b0}}};
    assign len_bad = (w0_len == '0) || ({1'b0, w0_len} > LEN_LIMIT);
`else
    assign len_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        len_d    = len_q;
        opc_d    = opc_q;
        inc_d    = inc_q;
        twd_d    = twd_q;
        tcdm_d   = tcdm_q;
        ext_d    = ext_q;
        count_d  = count_q;
        stride_d = stride_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && !len_bad) begin
                    len_d   = w0_len;
                    opc_d   = cmd_wdata_i[17];
                    inc_d   = cmd_wdata_i[18];
                    twd_d   = cmd_wdata_i[19];
                    state_d = ST_TCDM;
                    // 1D descriptors must present zero count/stride downstream
                    if (!cmd_wdata_i[19]) begin
                        count_d  = '0;
                        stride_d = '0;
                    end
                end
            end
            ST_TCDM: begin
                if (accept) begin
                    tcdm_d  = cmd_wdata_i[ADDR_WIDTH-1:0];
                    state_d = ST_EXT;
                end
            end
            ST_EXT: begin
                if (accept) begin
                    ext_d   = cmd_wdata_i[ADDR_WIDTH-1:0];
                    state_d = twd_q ? ST_COUNT : ST_PEND;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    count_d = cmd_wdata_i[TWD_COUNT_WIDTH-1:0];
                    state_d = ST_STRIDE;
                end
            end
            ST_STRIDE: begin
                if (accept) begin
                    stride_d = cmd_wdata_i[TWD_STRIDE_WIDTH-1:0];
                    state_d  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            opc_q    <= 1'b0;
            inc_q    <= 1'b0;
            twd_q    <= 1'b0;
            tcdm_q   <= '0;
            ext_q    <= '0;
            count_q  <= '0;
            stride_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            opc_q    <= opc_d;
            inc_q    <= inc_d;
            twd_q    <= twd_d;
            tcdm_q   <= tcdm_d;
            ext_q    <= ext_d;
            count_q  <= count_d;
            stride_q <= stride_d;
        end
    end

`ifdef MCHAN_CMD_LEN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = accept && (state_q == ST_IDLE) && len_bad;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign cmd_gnt_o        = accept;
    assign out_valid_o      = (state_q == ST_PEND);
    assign busy_o           = (state_q != ST_IDLE);
    assign out_len_o        = len_q;
    assign out_opc_o        = opc_q;
    assign out_inc_o        = inc_q;
    assign out_twd_o        = twd_q;
    assign out_tcdm_add_o   = tcdm_q;
    assign out_ext_add_o    = ext_q;
    assign out_twd_count_o  = count_q;
    assign out_twd_stride_o = stride_q;

endmodule
